// File: rtl/fsm_pkg.sv
// fsm_pkg: shared types and helpers for the table-driven Mealy controller.
//   entry_t        : one table entry {next state, output}
//   DEFAULT_ENTRY  : entry every slot resets to, and the lookup result for
//                    any state that does not exist
//   addr_compose() : builds the table address {state, symbol}
//   entry_legal()  : tells whether a config write may land in the table
// The entry field widths live here so that the top, the table and any
// software model agree on one layout. The top's STATE_W and OUT_W
// parameters default to these widths and must stay equal to them; change
// the widths here to retarget the slice.
package fsm_pkg;

  localparam int unsigned FSM_STATE_W = 3;
  localparam int unsigned FSM_OUT_W   = 1;

  typedef struct packed {
    logic [FSM_STATE_W-1:0] next;
    logic [FSM_OUT_W-1:0]   out;
  } entry_t;

  localparam entry_t DEFAULT_ENTRY = '{next: '0, out: '0};

  function automatic int unsigned addr_compose(input int unsigned st,
                                               input int unsigned sym,
                                               input int unsigned in_w);
    return (st << in_w) | sym;
  endfunction

  // A write is accepted only if both the addressed state and the stored
  // next state are inside 0..num_states-1.
  function automatic logic entry_legal(input int unsigned st,
                                       input int unsigned nxt,
                                       input int unsigned num_states);
    return (st < num_states) && (nxt < num_states);
  endfunction

endpackage

// File: rtl/mealy_table.sv
// mealy_table: flop-based transition/output table.
//   clk, rst   : clock, asynchronous active-low reset (all entries cleared)
//   we         : write strobe (already qualified by the caller)
//   wr_addr    : write address {state, symbol}
//   wr_data    : entry to store
//   rd_addr    : lookup address {state, symbol}
//   rd_data    : combinational lookup result; addresses past DEPTH read
//                DEFAULT_ENTRY
// A write lands on the clock edge, so a same-cycle read sees the old entry.
module mealy_table
  import fsm_pkg::*;
#(
  parameter int unsigned ADDR_W = 5,
  parameter int unsigned DEPTH  = 20
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  entry_t            wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output entry_t            rd_data
);

  entry_t r_mem [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < int'(DEPTH); i++) r_mem[i] <= DEFAULT_ENTRY;
    end else begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        if (we && (wr_addr == ADDR_W'(i))) r_mem[i] <= wr_data;
      end
    end
  end

  always_comb begin
    rd_data = DEFAULT_ENTRY;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (rd_addr == ADDR_W'(i)) rd_data = r_mem[i];
    end
  end

endmodule

// File: rtl/prog_mealy_fsm.sv
// prog_mealy_fsm: run-time programmable Mealy state machine.
//   clk, rst   : clock, asynchronous active-low reset
//   en         : advance enable (0 holds state and registered output)
//   data_in    : input symbol
//   data_out   : Mealy output (combinational, or registered when REG_OUT=1)
//   state      : current state
//   cfg_we     : table write strobe
//   cfg_addr   : entry address {state, symbol}
//   cfg_next   : next-state field to write
//   cfg_out    : output field to write
//   cfg_err    : sticky flag, set by a rejected write
//   clr        : synchronous clear of cfg_err and trans_cnt
//   trans_cnt  : saturating count of state changes
// The state machine has no fixed states of its own: the table defines them.
module prog_mealy_fsm
  import fsm_pkg::*;
#(
  parameter int unsigned NUM_STATES = 5,
  parameter int unsigned STATE_W    = FSM_STATE_W,
  parameter int unsigned IN_W       = 2,
  parameter int unsigned OUT_W      = FSM_OUT_W,
  parameter int unsigned REG_OUT    = 0,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  input  logic [IN_W-1:0]         data_in,
  output logic [OUT_W-1:0]        data_out,
  output logic [STATE_W-1:0]      state,
  input  logic                    cfg_we,
  input  logic [STATE_W+IN_W-1:0] cfg_addr,
  input  logic [STATE_W-1:0]      cfg_next,
  input  logic [OUT_W-1:0]        cfg_out,
  output logic                    cfg_err,
  input  logic                    clr,
  output logic [CNT_W-1:0]        trans_cnt
);

  localparam int unsigned ADDR_W = STATE_W + IN_W;
  localparam int unsigned DEPTH  = NUM_STATES << IN_W;

  logic [STATE_W-1:0] r_state;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_err;

  logic [ADDR_W-1:0]  w_rd_addr;
  entry_t             w_rd_entry;
  entry_t             w_wr_data;
  entry_t             w_entry;
  logic               w_legal;
  logic               w_wr_ok;
  logic               w_bad_wr;
  logic [STATE_W-1:0] w_next;
  logic [OUT_W-1:0]   w_out;

  assign w_rd_addr = ADDR_W'(addr_compose(32'(r_state), 32'(data_in), IN_W));

  assign w_legal  = entry_legal(32'(cfg_addr[ADDR_W-1:IN_W]), 32'(cfg_next),
                                NUM_STATES);
  assign w_wr_ok  = cfg_we && w_legal;
  assign w_bad_wr = cfg_we && !w_legal;
  assign w_wr_data = '{next: FSM_STATE_W'(cfg_next), out: FSM_OUT_W'(cfg_out)};

  mealy_table #(
    .ADDR_W(ADDR_W),
    .DEPTH (DEPTH)
  ) u_table (
    .clk    (clk),
    .rst    (rst),
    .we     (w_wr_ok),
    .wr_addr(cfg_addr),
    .wr_data(w_wr_data),
    .rd_addr(w_rd_addr),
    .rd_data(w_rd_entry)
  );

  // Writes can never create an illegal state, but an out-of-range state
  // still falls back to {next=0, out=0} so the machine always recovers.
  always_comb begin
    w_entry = DEFAULT_ENTRY;
    if (32'(r_state) < NUM_STATES) w_entry = w_rd_entry;
  end

  assign w_next = STATE_W'(w_entry.next);
  assign w_out  = OUT_W'(w_entry.out);

  // clr wins over a same-cycle increment or error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      if (en) r_state <= w_next;
      if (clr) begin
        r_cnt <= '0;
        r_err <= 1'b0;
      end else begin
        if (en && (w_next != r_state) && (r_cnt != '1)) r_cnt <= r_cnt + CNT_W'(1);
        if (w_bad_wr) r_err <= 1'b1;
      end
    end
  end

  generate
    if (REG_OUT != 0) begin : g_reg_out
      logic [OUT_W-1:0] r_data_out;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)    r_data_out <= '0;
        else if (en) r_data_out <= w_out;
      end
      assign data_out = r_data_out;
    end else begin : g_comb_out
      assign data_out = w_out;
    end
  endgenerate

  assign state     = r_state;
  assign cfg_err   = r_err;
  assign trans_cnt = r_cnt;

endmodule

// File: doc/prog_mealy_fsm.md
Name: prog_mealy_fsm

Overview:
Table-driven, run-time programmable Mealy state machine. It generalises the fixed five-state, 2-bit-input Mealy controller to parametrised state count, input width and output width. Transitions and outputs are held in a writable table, loaded over a simple config write port. It adds hold/enable, an optional registered output, write-error detection and a saturating transition counter. It sits between input sampling logic and downstream control, as a drop-in replacement for hand-coded small controllers.

Parameters:
NUM_STATES, 5, number of legal states (2..2**STATE_W)
STATE_W, 3, state encoding width
IN_W, 2, data_in width; table has 2**IN_W entries per state
OUT_W, 1, data_out width
REG_OUT, 0, 0 = combinational Mealy output; 1 = output registered (one-cycle latency)
CNT_W, 8, transition counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, asynchronous, active-low
en  in  1  advance enable; 0 holds state
data_in  in  IN_W  FSM input symbol
data_out  out  OUT_W  Mealy output
state  out  STATE_W  current state
cfg_we  in  1  table write strobe
cfg_addr  in  STATE_W+IN_W  entry address = {state, symbol}
cfg_next  in  STATE_W  next-state field to write
cfg_out  in  OUT_W  output field to write
cfg_err  out  1  sticky error: rejected config write
clr  in  1  synchronous clear of cfg_err and trans_cnt
trans_cnt  out  CNT_W  count of state changes, saturating

Behaviour:
- Reset (rst=0, async): state=0, every table entry = {next=0, out=0}, cfg_err=0, trans_cnt=0, registered data_out=0.
- Lookup: entry E = table[{state, data_in}]; 2**IN_W entries per state; addresses with state field >= NUM_STATES do not exist.
- Next state: on rising clk with en=1, state <= E.next; with en=0, state holds.
- Output, REG_OUT=0: data_out = E.out, combinational, independent of en.
- Output, REG_OUT=1: data_out <= E.out on rising clk when en=1; holds when en=0.
- Config write: on rising clk with cfg_we=1:
  - If cfg_addr state field < NUM_STATES and cfg_next < NUM_STATES, the entry is written.
  - Otherwise the write is dropped and cfg_err <= 1.
- Write/lookup collision: a write to the entry being looked up in the same cycle does not affect that cycle; lookup uses the old entry, and the new entry takes effect from the next cycle.
- Writes are allowed while running (en=1); no stall.
- State legality: state never leaves 0..NUM_STATES-1, guaranteed by write checking. Implementation still maps any illegal state to next=0, out=0 (defensive default).
- trans_cnt: +1 on rising clk when en=1 and E.next != state. Saturates at 2**CNT_W-1.
- clr: synchronous. Sets trans_cnt=0 and cfg_err=0, with priority over a simultaneous increment or error. Does not affect state or table.
- Reset mid-operation forces all reset values immediately, including the table; software must reprogram.

Decomposition:
- Shared package fsm_pkg holds:
  - table entry struct {next, out}
  - address-compose function {state, symbol}
  - entry-legality function
  - default-entry constant
- One sub-module, mealy_table: flop-based register file with async reset, one write port and one combinational read port.
- The top holds the state register, output register, error flag and counter.

Test Plan:
- Reset: after rst release, state=0, data_out=0, trans_cnt=0, cfg_err=0; data_in=2'b11 with en=1 keeps state=0.
- Program classic 5-state table (st0: 00->0/0, 01->4/1, 10->1/1, 11->2/1; remaining states per team table), drive 10,10,11,11 -> states 1,2,3,3; data_out matches table each cycle; trans_cnt=3.
- Collision: in state 0, write table[{0,01}]={3,0} while data_in=01, en=1 -> next state 4 with out=1 this cycle; repeat from state 0 -> state 3, out=0.
- Illegal write: cfg_addr state field=5, or cfg_next=6 -> entry unchanged, cfg_err=1 until clr; clr with a simultaneous bad write -> cfg_err=0.
- CNT_W=2: 5 state changes -> trans_cnt stays 3; en=0 for 3 cycles -> state and trans_cnt frozen.
- REG_OUT=1: data_out lags combinational value by exactly one enabled cycle. Async rst asserted mid-sequence -> state=0 and data_out=0 without a clock edge.
